keyed_dup_fsm: RTL and testbench
================================

# keyed_dup_fsm

Parametrised key-locked sequencer FSM for the locking/trojan benchmark set, generalising the single hand-coded duplicate-state lock to configurable state count, key width, lock points and trigger-count payload. Real states S0..S(N-1) form a ring advanced by `adv`. Each lock point sends a wrong key into a shadow decoy ring D0..D(N-1) that produces plausible but shifted outputs. An optional counter-triggered payload suppresses outputs on one chosen transition after a set number of uses.

## Interface
- N_STATES, 8: real states in ring (≥3); decoy ring same size
- KEY_W, 4: key width
- CORRECT_KEY, 4'hA: unlocking key value (KEY_W bits)
- LOCK_MASK, 8'b0000_0100: bit k=1 makes exit Sk→S(k+1) key-checked
- TROJAN_EN, 1: 1 enables trigger counter and payload
- TROJAN_STATE, 5: real state whose adv-exit is counted
- TRIG_COUNT, 5: exit number (1-based) from which payload fires (≥1)
- DBG, 0: 1 drives `dbg_decoy`; 0 ties it low
- clk  in  1  clock; state and counter update on falling edge
- rst  in  1  asynchronous, active-high reset
- adv  in  1  advance request
- jmp  in  1  return-to-origin request; priority over adv
- keyinput  in  KEY_W  key bits
- y  out  N_STATES  one-hot Mealy transition outputs, combinational
- dbg_decoy  out  1  high while in decoy ring (DBG=1 only)

## Operation
- State encoding: real Sk and decoy Dk, 2·N_STATES states. Trigger counter `tcnt`, width clog2(TRIG_COUNT+1), saturating at TRIG_COUNT.
- Reset: pr_state=S0, tcnt=0. y follows from S0 and inputs. dbg_decoy=0.
- Default each evaluation: y=0; next = current.
- In Sk:
  - jmp=1 → S0, y[0]=1.
  - Else adv=1, LOCK_MASK[k]=0 → S((k+1) mod N), y[(k+1) mod N]=1.
  - Else adv=1, LOCK_MASK[k]=1, keyinput==CORRECT_KEY → S((k+1) mod N), y[(k+1) mod N]=1.
  - Else adv=1, LOCK_MASK[k]=1, key mismatch → D((k+1) mod N), y[(k+1) mod N]=1. The mismatch is invisible on this transition.
  - Neither → hold, y=0.
- In Dk:
  - jmp=1 → D0, y[0]=1.
  - Else adv=1 → D((k+1) mod N), y[(k+2) mod N]=1.
  - Neither → hold, y=0.
  - The key is ignored in decoys. Only rst returns to the real ring.
- Payload (TROJAN_EN=1): on an adv-exit from S_TROJAN_STATE (jmp=0), if tcnt ≥ TRIG_COUNT−1, y is forced to all-zero for that transition. The state still advances. tcnt increments (saturating) at the falling edge committing that exit. Exits via jmp, and decoy-ring exits, are not counted.
- TROJAN_EN=0: tcnt held 0, payload never fires.

## Timing
- y is purely combinational from pr_state, adv, jmp, keyinput and tcnt. There is no registered output delay.
- pr_state and tcnt load at negedge clk. rst asserts immediately (asynchronously), independent of clk.
- Reset mid-operation (any state, any tcnt) → S0 and tcnt=0 at once; y re-evaluates from S0.
- Simultaneous adv and jmp → jmp wins everywhere.
- Wrap: S(N−1) adv → S0 with y[0]; D(N−1) adv → D0 with y[1]. In decoy, wrap of (k+2) is mod N.
- Key may change every cycle. Only its value at the lock-point falling edge matters.

## Test plan
- Defaults, key=4'hA: reset, 8 adv cycles → y pulses 1,2,…,7,0 one-hot in order; back in S0; dbg_decoy=0 throughout.
- Key=4'h3: reset, 3 adv → y[1],y[2],y[3]; 4th adv → y[5] (decoy D3); jmp → y[0], still decoy (DBG=1: dbg_decoy=1); rst → S0, dbg_decoy=0.
- Trigger: key=4'hA, cycle full ring 6 times. Exit S5→S6 → y[6]=1 on passes 1–4, y=0 on passes 5 and 6. The state reaches S7 each pass.
- Reset after trigger: mid-ring rst then ring pass → S5 exit gives y[6]=1 again (tcnt cleared).
- adv=jmp=1 in S4 → y=8'b0000_0001, next S0. adv=jmp=0 in S4 → y=0 and state held over 3 falling edges.
- TROJAN_EN=0: 10 passes through S5 → y[6]=1 every time.

Source files
------------

// File: rtl/keyed_dup_fsm_if.sv
// Handshake bundle for keyed_dup_fsm: sequencer requests and key in,
// one-hot Mealy transition outputs and decoy debug flag out.
interface keyed_dup_fsm_if #(
  parameter int N_STATES = 8,
  parameter int KEY_W    = 4
);
  logic                adv;
  logic                jmp;
  logic [KEY_W-1:0]    keyinput;
  logic [N_STATES-1:0] y;
  logic                dbg_decoy;

  modport master (output adv, jmp, keyinput, input y, dbg_decoy);
  modport slave  (input adv, jmp, keyinput, output y, dbg_decoy);
endinterface

// File: rtl/keyed_dup_fsm.sv
// Key-locked ring sequencer: wrong keys at lock points divert into a shadow
// decoy ring, and an optional use-counter silences one chosen transition.
module keyed_dup_fsm #(
  parameter int                  N_STATES     = 8,
  parameter int                  KEY_W        = 4,
  parameter logic [KEY_W-1:0]    CORRECT_KEY  = 4'hA,
  parameter logic [N_STATES-1:0] LOCK_MASK    = 8'b0000_0100,
  parameter bit                  TROJAN_EN    = 1'b1,
  parameter int                  TROJAN_STATE = 5,
  parameter int                  TRIG_COUNT   = 5,
  parameter bit                  DBG          = 1'b0
) (
  input logic            clk,
  input logic            rst,
  keyed_dup_fsm_if.slave bus
);

  localparam int IW = (N_STATES > 1) ? $clog2(N_STATES) : 1;
  localparam int TW = (TRIG_COUNT > 0) ? $clog2(TRIG_COUNT + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(N_STATES - 1);
  localparam logic [IW-1:0] TROJAN_IDX = IW'(TROJAN_STATE);
  localparam logic [TW-1:0] TRIG_FIRE  = TW'(TRIG_COUNT - 1);
  localparam logic [TW-1:0] TRIG_MAX   = TW'(TRIG_COUNT);

  typedef enum logic {
    RING_REAL  = 1'b0,
    RING_DECOY = 1'b1
  } ring_t;

  ring_t               ring, ring_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [IW-1:0]       idx_p1, idx_p2;
  logic [TW-1:0]       tcnt, tcnt_nxt;
  logic [N_STATES-1:0] y_c;

  assign idx_p1 = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign idx_p2 = (idx_p1 == LAST_IDX) ? '0 : idx_p1 + 1'b1;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ring <= RING_REAL;
      idx  <= '0;
      tcnt <= '0;
    end else begin
      ring <= ring_nxt;
      idx  <= idx_nxt;
      tcnt <= tcnt_nxt;
    end
  end

  // Decoy outputs lead the real ring by one position, so a diverted run
  // looks plausible but is shifted; only rst ever leaves the decoy ring.
  always_comb begin
    ring_nxt = ring;
    idx_nxt  = idx;
    tcnt_nxt = tcnt;
    y_c      = '0;
    unique case (ring)
      RING_REAL: begin
        if (bus.jmp) begin
          idx_nxt = '0;
          y_c[0]  = 1'b1;
        end else if (bus.adv) begin
          idx_nxt     = idx_p1;
          y_c[idx_p1] = 1'b1;
          if (LOCK_MASK[idx] && (bus.keyinput != CORRECT_KEY))
            ring_nxt = RING_DECOY;
          if (TROJAN_EN && (idx == TROJAN_IDX)) begin
            if (tcnt >= TRIG_FIRE)
              y_c = '0;
            if (tcnt < TRIG_MAX)
              tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      RING_DECOY: begin
        if (bus.jmp) begin
          idx_nxt = '0;
          y_c[0]  = 1'b1;
        end else if (bus.adv) begin
          idx_nxt     = idx_p1;
          y_c[idx_p2] = 1'b1;
        end
      end
      default: begin
        ring_nxt = RING_REAL;
        idx_nxt  = '0;
      end
    endcase
  end

  assign bus.y         = y_c;
  assign bus.dbg_decoy = DBG && (ring == RING_DECOY);

endmodule

// File: tb/tb_keyed_dup_fsm.sv
// Scoreboard bench for keyed_dup_fsm: DUT A (trojan on, debug on) and
// DUT B (trojan off) are driven with directed vectors and checked at posedge.
module tb_keyed_dup_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  keyed_dup_fsm_if #(.N_STATES(8), .KEY_W(4)) ifa ();
  keyed_dup_fsm_if #(.N_STATES(8), .KEY_W(4)) ifb ();

  keyed_dup_fsm #(.DBG(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  keyed_dup_fsm #(.TROJAN_EN(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct packed {
    logic       sel;
    logic [7:0] y;
    logic       dbg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   steps  = 0;

  // Inputs change just after the committing falling edge; the expected
  // Mealy response is queued for the monitor to compare at the rising edge.
  task automatic applyStimulus(input logic sel, input logic r, input logic a,
                               input logic j, input logic [3:0] k,
                               input logic [7:0] ey, input logic ed);
    exp_t e;
    @(negedge clk);
    #1;
    rst          = r;
    ifa.adv      = sel ? 1'b0 : a;
    ifa.jmp      = sel ? 1'b0 : j;
    ifa.keyinput = k;
    ifb.adv      = sel ? a : 1'b0;
    ifb.jmp      = sel ? j : 1'b0;
    ifb.keyinput = k;
    e.sel = sel;
    e.y   = ey;
    e.dbg = ed;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e, input int step);
    logic [7:0] act_y;
    logic       act_d;
    act_y = e.sel ? ifb.y : ifa.y;
    act_d = e.sel ? ifb.dbg_decoy : ifa.dbg_decoy;
    checks++;
    if (act_y !== e.y || act_d !== e.dbg) begin
      errors++;
      $display("[TB] FAIL dut%0d step%0d: got y=%b dbg=%b, expected y=%b dbg=%b",
               e.sel, step, act_y, act_d, e.y, e.dbg);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        steps++;
        checkOutput(e, steps);
      end
    end
  end

  function automatic logic [7:0] oh(input int i);
    return 8'(1) << (i % 8);
  endfunction

  task automatic advA(input logic [3:0] k, input int ey_idx, input logic ed);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, k, oh(ey_idx), ed);
  endtask

  initial begin
    ifa.adv = 1'b0; ifa.jmp = 1'b0; ifa.keyinput = 4'hA;
    ifb.adv = 1'b0; ifb.jmp = 1'b0; ifb.keyinput = 4'hA;

    // Reset state: y follows S0 and inputs even while held in reset
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 8'h02, 1'b0);

    // Full ring with correct key
    for (int k = 0; k < 8; k++) advA(4'hA, k + 1, 1'b0);
    advA(4'hA, 1, 1'b0);

    // Wrong key diverts at S2, decoy outputs shifted, jmp stays in decoy
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'h00, 1'b0);
    advA(4'h3, 1, 1'b0);
    advA(4'h3, 2, 1'b0);
    advA(4'h3, 3, 1'b0);
    advA(4'h3, 5, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 8'h01, 1'b1);
    advA(4'hA, 2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'h00, 1'b0);
    advA(4'h3, 1, 1'b0);

    // Only the key at the lock edge matters; decoy wrap D7->D0 gives y[1]
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'h00, 1'b0);
    advA(4'h3, 1, 1'b0);
    advA(4'h3, 2, 1'b0);
    advA(4'hA, 3, 1'b0);
    advA(4'h3, 4, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    advA(4'h0, 1, 1'b0);
    advA(4'h0, 2, 1'b0);
    advA(4'h0, 3, 1'b0);
    advA(4'h0, 5, 1'b1);
    advA(4'h0, 6, 1'b1);
    advA(4'h0, 7, 1'b1);
    advA(4'h0, 0, 1'b1);
    advA(4'h0, 1, 1'b1);
    advA(4'h0, 2, 1'b1);

    // Trigger: S5 exit silenced from the fifth pass on, state still advances
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 8'h00, 1'b0);
    for (int p = 1; p <= 6; p++)
      for (int k = 0; k < 8; k++)
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'hA,
                      (k == 5 && p >= 5) ? 8'h00 : oh(k + 1), 1'b0);

    // Mid-ring reset clears the trigger count
    advA(4'hA, 1, 1'b0);
    advA(4'hA, 2, 1'b0);
    advA(4'hA, 3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) advA(4'hA, k + 1, 1'b0);

    // jmp beats adv in S4; idle in S4 holds the state
    for (int k = 0; k < 4; k++) advA(4'hA, k + 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'h01, 1'b0);
    advA(4'hA, 1, 1'b0);
    advA(4'hA, 2, 1'b0);
    advA(4'hA, 3, 1'b0);
    advA(4'hA, 4, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'h00, 1'b0);
    advA(4'hA, 5, 1'b0);

    // Trojan disabled: S5 exit always shows y[6]
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 8'h00, 1'b0);
    for (int p = 0; p < 10; p++)
      for (int k = 0; k < 8; k++)
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hA, oh(k + 1), 1'b0);

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      void'(sb.pop_front());
      checks++;
      errors++;
      $display("[TB] FAIL drain: got no sample, expected a queued check");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
